// File: rtl/rv32i_types.sv
// rv32i_types: shared widths and the CDB / reservation-station entry types.
package rv32i_types;
  localparam int ROB_W = 5;
  localparam int XLEN = 32;
  localparam int PAYLOAD_W = 64;
  localparam int AGE_W = 4;
  typedef struct packed {
    logic valid;
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0] data;
  } cdb_t;
  typedef struct packed {
    logic ready;
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0] data;
  } rs_src_t;
  typedef struct packed {
    logic valid;
    logic [PAYLOAD_W-1:0] payload;
    logic [ROB_W-1:0] rd_tag;
    rs_src_t rs1;
    rs_src_t rs2;
    logic [AGE_W-1:0] age;
  } rs_entry_t;
endpackage

// File: rtl/rs_if.sv
// rs_if: dispatch, wakeup broadcast and issue signals of the reservation station.
interface rs_if #(
  parameter int DEPTH = 4,
  parameter int NUM_CDB = 2,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PAYLOAD_WIDTH = 64
);
  logic flush;
  logic dispatch_valid;
  logic dispatch_ready;
  logic [PAYLOAD_WIDTH-1:0] dispatch_payload;
  logic [ROB_IDX_WIDTH-1:0] dispatch_rd_tag;
  logic dispatch_rs1_ready;
  logic [ROB_IDX_WIDTH-1:0] dispatch_rs1_tag;
  logic [DATA_WIDTH-1:0] dispatch_rs1_data;
  logic dispatch_rs2_ready;
  logic [ROB_IDX_WIDTH-1:0] dispatch_rs2_tag;
  logic [DATA_WIDTH-1:0] dispatch_rs2_data;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB-1:0][ROB_IDX_WIDTH-1:0] cdb_tag;
  logic [NUM_CDB-1:0][DATA_WIDTH-1:0] cdb_data;
  logic issue_valid;
  logic issue_ready;
  logic [PAYLOAD_WIDTH-1:0] issue_payload;
  logic [ROB_IDX_WIDTH-1:0] issue_rd_tag;
  logic [DATA_WIDTH-1:0] issue_rs1_data;
  logic [DATA_WIDTH-1:0] issue_rs2_data;
  logic [$clog2(DEPTH):0] occupancy;
  modport master (
    output flush, dispatch_valid, dispatch_payload, dispatch_rd_tag,
           dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_data,
           dispatch_rs2_ready, dispatch_rs2_tag, dispatch_rs2_data,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  dispatch_ready, issue_valid, issue_payload, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, occupancy
  );
  modport slave (
    input  flush, dispatch_valid, dispatch_payload, dispatch_rd_tag,
           dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_data,
           dispatch_rs2_ready, dispatch_rs2_tag, dispatch_rs2_data,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output dispatch_ready, issue_valid, issue_payload, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, occupancy
  );
endinterface

// File: rtl/rs_oldest_select.sv
// rs_oldest_select: one-hot grant of the eligible entry with the largest (oldest) age.
module rs_oldest_select
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] i_elig,
  input  logic [DEPTH-1:0][AGE_W-1:0] i_age,
  output logic [DEPTH-1:0] o_grant,
  output logic o_valid
);
  always_comb begin
    o_grant = i_elig;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (i_elig[j] && i_age[j] > i_age[i]) o_grant[i] = 1'b0;
  end
  assign o_valid = |i_elig;
endmodule

// File: rtl/rs_array.sv
// rs_array: reservation station with tag wakeup, dispatch bypass and oldest-ready issue.
module rs_array
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_CDB = 2,
  parameter int ROB_IDX_WIDTH = ROB_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int PAYLOAD_WIDTH = PAYLOAD_W
) (
  input logic clk,
  input logic rst,
  rs_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  rs_entry_t [DEPTH-1:0] r_ent, w_nxt;
  cdb_t [NUM_CDB-1:0] w_cdb;
  logic [DEPTH-1:0] w_elig, w_grant;
  logic [DEPTH-1:0][AGE_W-1:0] w_age;
  logic w_any, w_disp, w_iss_fire;
  logic [IDX_W-1:0] w_free;
  logic [CNT_W-1:0] w_occ;
  logic [PAYLOAD_WIDTH-1:0] w_iss_payload;
  logic [ROB_IDX_WIDTH-1:0] w_iss_rd;
  logic [DATA_WIDTH-1:0] w_iss_d1, w_iss_d2;
  logic [AGE_W-1:0] w_iss_age;
  // Lowest CDB port wins: it is applied last while scanning downward.
  function automatic rs_src_t wake(rs_src_t s, cdb_t [NUM_CDB-1:0] c);
    wake = s;
    for (int p = NUM_CDB - 1; p >= 0; p--)
      if (!s.ready && c[p].valid && c[p].tag == s.tag) wake = '{1'b1, s.tag, c[p].data};
  endfunction
  for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb
    assign w_cdb[g] = {bus.cdb_valid[g], bus.cdb_tag[g], bus.cdb_data[g]};
  end
  for (genvar e = 0; e < DEPTH; e++) begin : g_elig
    assign w_elig[e] = r_ent[e].valid & r_ent[e].rs1.ready & r_ent[e].rs2.ready;
    assign w_age[e] = r_ent[e].age;
  end
  rs_oldest_select #(.DEPTH(DEPTH)) u_sel (
    .i_elig(w_elig), .i_age(w_age), .o_grant(w_grant), .o_valid(w_any)
  );
  always_comb begin
    w_free = '0;
    w_occ = '0;
    w_iss_payload = '0;
    w_iss_rd = '0;
    w_iss_d1 = '0;
    w_iss_d2 = '0;
    w_iss_age = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_free = !r_ent[i].valid ? IDX_W'(i) : w_free;
      w_occ = w_occ + CNT_W'(r_ent[i].valid);
      if (w_grant[i]) begin
        w_iss_payload = r_ent[i].payload;
        w_iss_rd = r_ent[i].rd_tag;
        w_iss_d1 = r_ent[i].rs1.data;
        w_iss_d2 = r_ent[i].rs2.data;
        w_iss_age = r_ent[i].age;
      end
    end
  end
  assign bus.dispatch_ready = w_occ < CNT_W'(DEPTH);
  assign bus.occupancy = w_occ;
  assign bus.issue_valid = w_any;
  assign bus.issue_payload = w_iss_payload;
  assign bus.issue_rd_tag = w_iss_rd;
  assign bus.issue_rs1_data = w_iss_d1;
  assign bus.issue_rs2_data = w_iss_d2;
  assign w_disp = bus.dispatch_valid & bus.dispatch_ready;
  assign w_iss_fire = w_any & bus.issue_ready;
  // Ages form a dense 0..n-1 ranking; entries older than an issued one close the gap.
  always_comb begin
    w_nxt = r_ent;
    for (int i = 0; i < DEPTH; i++)
      if (r_ent[i].valid) begin
        w_nxt[i].rs1 = wake(r_ent[i].rs1, w_cdb);
        w_nxt[i].rs2 = wake(r_ent[i].rs2, w_cdb);
        w_nxt[i].age = r_ent[i].age + AGE_W'(w_disp) - AGE_W'(w_iss_fire && w_iss_age < r_ent[i].age);
        w_nxt[i].valid = !(w_iss_fire && w_grant[i]);
      end
    if (w_disp)
      w_nxt[w_free] = '{1'b1, bus.dispatch_payload, bus.dispatch_rd_tag,
        wake(rs_src_t'{bus.dispatch_rs1_ready, bus.dispatch_rs1_tag, bus.dispatch_rs1_data}, w_cdb),
        wake(rs_src_t'{bus.dispatch_rs2_ready, bus.dispatch_rs2_tag, bus.dispatch_rs2_data}, w_cdb),
        AGE_W'(0)};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ent <= '0;
    else if (bus.flush) r_ent <= '0;
    else r_ent <= w_nxt;
endmodule
